// File: rtl/ethhelper_pkg.sv
// rtl/ethhelper_pkg.sv - shared record layout, replay FSM states and AXI encodings
package ethhelper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2
  } ax_state_e;

  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
  localparam logic [3:0] AXI_CACHE_BUF_MOD = 4'b0011;

  // Record layout, LSB first: addr, timestamp, len, id, type.
  // The snoop-side packer builds words with the same offsets.
  function automatic int rec_ts_lsb(input int addr_w);
    return addr_w;
  endfunction

  function automatic int rec_len_lsb(input int addr_w, input int timer_w);
    return addr_w + timer_w;
  endfunction

  function automatic int rec_id_lsb(input int addr_w, input int timer_w, input int len_w);
    return addr_w + timer_w + len_w;
  endfunction

  function automatic int rec_type_lsb(input int addr_w, input int timer_w, input int len_w,
                                      input int id_w);
    return addr_w + timer_w + len_w + id_w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with registered full/empty and a level output
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  // Full/empty come from flops, so a pop never frees a slot for a same-cycle push.
  assign do_push  = push & ~full_q;
  assign do_pop   = pop & ~empty_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign full     = full_q;
  assign empty    = empty_q;
  assign level    = level_q;

  // Next pointer, level and flag values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    full_d  = (level_d == (AW+1)'(DEPTH));
    empty_d = (level_d == '0);
  end

  // Pointer and flag registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/stream_to_axi_ax.sv
// rtl/stream_to_axi_ax.sv - replays captured AR/AW stream records as AXI4 address transactions
module stream_to_axi_ax
  import ethhelper_pkg::*;
#(
  parameter int                           DATA_WIDTH        = 128,
  parameter int                           ADDR_WIDTH        = 64,
  parameter int                           ID_WIDTH          = 32,
  parameter int                           BURST_LEN         = 8,
  parameter int                           LOCK_WIDTH        = 2,
  parameter int                           USER_WIDTH        = 64,
  parameter int                           STREAM_TYPE_WIDTH = 3,
  parameter logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE       = '0,
  parameter int                           TIMER_WIDTH       = 20,
  parameter int                           FIFO_DEPTH        = 4,
  parameter logic [2:0]                   AXSIZE            = 3'b100
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [DATA_WIDTH-1:0]         stream_data,
  input  logic                          stream_valid,
  output logic                          stream_ready,
  input  logic                          pace_en,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   drop_count,
  output logic [ID_WIDTH-1:0]           AXIM_axid,
  output logic [ADDR_WIDTH-1:0]         AXIM_axaddr,
  output logic [BURST_LEN-1:0]          AXIM_axlen,
  output logic [2:0]                    AXIM_axsize,
  output logic [1:0]                    AXIM_axburst,
  output logic [LOCK_WIDTH-1:0]         AXIM_axlock,
  output logic [3:0]                    AXIM_axcache,
  output logic [2:0]                    AXIM_axprot,
  output logic [3:0]                    AXIM_axregion,
  output logic [3:0]                    AXIM_axqos,
  output logic [USER_WIDTH-1:0]         AXIM_axuser,
  output logic                          AXIM_axvalid,
  input  logic                          AXIM_axready
);

  localparam int TS_LSB   = rec_ts_lsb(ADDR_WIDTH);
  localparam int LEN_LSB  = rec_len_lsb(ADDR_WIDTH, TIMER_WIDTH);
  localparam int ID_LSB   = rec_id_lsb(ADDR_WIDTH, TIMER_WIDTH, BURST_LEN);
  localparam int TYPE_LSB = rec_type_lsb(ADDR_WIDTH, TIMER_WIDTH, BURST_LEN, ID_WIDTH);
  localparam int ENTRY_W  = TYPE_LSB;
  localparam int REC_W    = TYPE_LSB + STREAM_TYPE_WIDTH;

  logic [ENTRY_W-1:0]     head;
  logic                   fifo_full, fifo_empty;
  logic                   type_match, stream_hs, push, pop;
  logic [TIMER_WIDTH-1:0] head_ts, delta;
  logic                   go;

  ax_state_e              state_q, state_d;
  logic [TIMER_WIDTH-1:0] elapsed_q, elapsed_d;
  logic [TIMER_WIDTH-1:0] ts_prev_q, ts_prev_d;
  logic                   have_prev_q, have_prev_d;
  logic [15:0]            drop_q, drop_d;

  // Bits above the type field carry nothing for this receiver.
  generate
    if (DATA_WIDTH > REC_W) begin : g_spare
      logic unused_spare;
      assign unused_spare = ^stream_data[DATA_WIDTH-1:REC_W];
    end
  endgenerate

  assign type_match   = (stream_data[TYPE_LSB +: STREAM_TYPE_WIDTH] == STREAM_TYPE);
  assign stream_ready = ~fifo_full;
  assign stream_hs    = stream_valid & stream_ready;
  assign push         = stream_hs & type_match;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data (stream_data[ENTRY_W-1:0]),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Modular subtraction makes timestamp wrap transparent.
  assign head_ts = head[TS_LSB +: TIMER_WIDTH];
  assign delta   = head_ts - ts_prev_q;
  assign go      = ~pace_en | ~have_prev_q | (elapsed_q >= delta);

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // FSM next state: pace from IDLE/WAIT, hold ISSUE until accepted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!fifo_empty) state_d = go ? ST_ISSUE : ST_WAIT;
      ST_WAIT:  if (go) state_d = ST_ISSUE;
      ST_ISSUE: if (AXIM_axready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: valid only in ISSUE, pop on address handshake.
  always_comb begin
    AXIM_axvalid = (state_q == ST_ISSUE);
    pop          = (state_q == ST_ISSUE) & AXIM_axready;
  end

  // Pacing state: elapsed counter, previous timestamp and its validity; drop counter.
  always_comb begin
    elapsed_d   = (elapsed_q == '1) ? elapsed_q : elapsed_q + 1'b1;
    ts_prev_d   = ts_prev_q;
    have_prev_d = have_prev_q;
    drop_d      = drop_q;
    if (pop) begin
      elapsed_d   = '0;
      ts_prev_d   = head_ts;
      have_prev_d = 1'b1;
    end else if (state_q == ST_IDLE && fifo_empty) begin
      have_prev_d = 1'b0;
    end
    if (stream_hs && !type_match && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
  end

  // Pacing and drop registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      elapsed_q   <= '0;
      ts_prev_q   <= '0;
      have_prev_q <= 1'b0;
      drop_q      <= '0;
    end else begin
      elapsed_q   <= elapsed_d;
      ts_prev_q   <= ts_prev_d;
      have_prev_q <= have_prev_d;
      drop_q      <= drop_d;
    end
  end

  assign drop_count    = drop_q;
  assign AXIM_axid     = head[ID_LSB +: ID_WIDTH];
  assign AXIM_axlen    = head[LEN_LSB +: BURST_LEN];
  assign AXIM_axaddr   = head[ADDR_WIDTH-1:0];
  assign AXIM_axsize   = AXSIZE;
  assign AXIM_axburst  = AXI_BURST_INCR;
  assign AXIM_axlock   = '0;
  assign AXIM_axcache  = AXI_CACHE_BUF_MOD;
  assign AXIM_axprot   = '0;
  assign AXIM_axregion = '0;
  assign AXIM_axqos    = '0;
  assign AXIM_axuser   = '0;

endmodule

// File: tb/tb_stream_to_axi_ax.sv
// tb/tb_stream_to_axi_ax.sv - directed self-checking bench for stream_to_axi_ax
module tb_stream_to_axi_ax;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic [127:0] stream_data = '0;
  logic         stream_valid = 1'b0;
  logic         stream_ready;
  logic         pace_en = 1'b0;
  logic [2:0]   fifo_level;
  logic [15:0]  drop_count;
  logic [31:0]  AXIM_axid;
  logic [63:0]  AXIM_axaddr;
  logic [7:0]   AXIM_axlen;
  logic [2:0]   AXIM_axsize;
  logic [1:0]   AXIM_axburst;
  logic [1:0]   AXIM_axlock;
  logic [3:0]   AXIM_axcache;
  logic [2:0]   AXIM_axprot;
  logic [3:0]   AXIM_axregion;
  logic [3:0]   AXIM_axqos;
  logic [63:0]  AXIM_axuser;
  logic         AXIM_axvalid;
  logic         AXIM_axready = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  int          st_cyc[$];
  int          ax_cyc[$];
  logic [63:0] ax_addr[$];
  logic [31:0] ax_id[$];
  logic [7:0]  ax_len[$];
  logic [1:0]  ax_burst[$];
  logic [2:0]  ax_size[$];
  logic [3:0]  ax_cache[$];

  stream_to_axi_ax dut (
    .clk           (clk),
    .resetn        (resetn),
    .stream_data   (stream_data),
    .stream_valid  (stream_valid),
    .stream_ready  (stream_ready),
    .pace_en       (pace_en),
    .fifo_level    (fifo_level),
    .drop_count    (drop_count),
    .AXIM_axid     (AXIM_axid),
    .AXIM_axaddr   (AXIM_axaddr),
    .AXIM_axlen    (AXIM_axlen),
    .AXIM_axsize   (AXIM_axsize),
    .AXIM_axburst  (AXIM_axburst),
    .AXIM_axlock   (AXIM_axlock),
    .AXIM_axcache  (AXIM_axcache),
    .AXIM_axprot   (AXIM_axprot),
    .AXIM_axregion (AXIM_axregion),
    .AXIM_axqos    (AXIM_axqos),
    .AXIM_axuser   (AXIM_axuser),
    .AXIM_axvalid  (AXIM_axvalid),
    .AXIM_axready  (AXIM_axready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes are logged half a cycle before the edge that completes them.
  always @(negedge clk) begin
    if (resetn) begin
      if (stream_valid && stream_ready) st_cyc.push_back(cyc);
      if (AXIM_axvalid && AXIM_axready) begin
        ax_cyc.push_back(cyc);
        ax_addr.push_back(AXIM_axaddr);
        ax_id.push_back(AXIM_axid);
        ax_len.push_back(AXIM_axlen);
        ax_burst.push_back(AXIM_axburst);
        ax_size.push_back(AXIM_axsize);
        ax_cache.push_back(AXIM_axcache);
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [127:0] mk_rec(input logic [2:0] typ, input logic [31:0] id,
                                          input logic [7:0] len, input logic [19:0] ts,
                                          input logic [63:0] addr);
    return {1'b0, typ, id, len, ts, addr};
  endfunction

  task automatic send_rec(input logic [127:0] rec, input int budget, output bit ok);
    ok = 1'b0;
    stream_data  = rec;
    stream_valid = 1'b1;
    for (int i = 0; i < budget && !ok; i++) begin
      if (stream_ready) ok = 1'b1;
      step();
    end
    stream_valid = 1'b0;
  endtask

  task automatic wait_ax(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && ax_addr.size() < n; i++) step();
    check_eq(tag, ax_addr.size(), n);
  endtask

  task automatic clear_logs();
    st_cyc.delete();
    ax_cyc.delete();
    ax_addr.delete();
    ax_id.delete();
    ax_len.delete();
    ax_burst.delete();
    ax_size.delete();
    ax_cache.delete();
  endtask

  bit ok;
  int accepted;

  initial begin
    // Reset state
    step();
    check_eq("rst_axvalid", AXIM_axvalid, 0);
    check_eq("rst_level", fifo_level, 0);
    check_eq("rst_drop", drop_count, 0);
    step();
    resetn = 1'b1;
    step();
    check_eq("rst_ready", stream_ready, 1);

    // Single unpaced record: valid two cycles after the stream handshake
    AXIM_axready = 1'b1;
    send_rec(mk_rec(3'd0, 32'd5, 8'd3, 20'd100, 64'h1000), 4, ok);
    check_eq("single_accept", ok, 1);
    wait_ax("single_issue", 1, 10);
    if (ax_addr.size() == 1 && st_cyc.size() == 1) begin
      check_eq("single_latency", ax_cyc[0] - st_cyc[0], 2);
      check_eq("single_id", ax_id[0], 5);
      check_eq("single_len", ax_len[0], 3);
      check_eq("single_addr", ax_addr[0], 64'h1000);
      check_eq("single_burst", ax_burst[0], 2'b01);
      check_eq("single_size", ax_size[0], 3'b100);
      check_eq("single_cache", ax_cache[0], 4'b0011);
    end
    step(); step(); step();
    check_eq("single_level", fifo_level, 0);
    check_eq("single_count", ax_addr.size(), 1);
    check_eq("single_const", {AXIM_axlock, AXIM_axprot, AXIM_axregion, AXIM_axqos, AXIM_axuser != 0}, 0);

    // Non-matching type is dropped and counted, saturating at 0xFFFF
    send_rec(mk_rec(3'b010, 32'd9, 8'd1, 20'd5, 64'h2000), 4, ok);
    check_eq("drop_accept", ok, 1);
    check_eq("drop_ready", stream_ready, 1);
    check_eq("drop_count1", drop_count, 1);
    step(); step(); step();
    check_eq("drop_noissue", ax_addr.size(), 1);
    check_eq("drop_level", fifo_level, 0);
    stream_data  = mk_rec(3'b010, 32'd9, 8'd1, 20'd5, 64'h2000);
    stream_valid = 1'b1;
    repeat (65539) step();
    stream_valid = 1'b0;
    check_eq("drop_sat", drop_count, 16'hFFFF);
    step();
    check_eq("drop_sat_hold", drop_count, 16'hFFFF);

    // Back-pressure: only four records fit, head fields hold steady
    clear_logs();
    AXIM_axready = 1'b0;
    accepted = 0;
    for (int k = 0; k < 6; k++) begin
      send_rec(mk_rec(3'd0, 32'(16 + k), 8'(k), 20'd0, 64'h4000 + 64'(k * 16'h100)), 6, ok);
      if (ok) accepted++;
    end
    check_eq("bp_accepted", accepted, 4);
    check_eq("bp_ready", stream_ready, 0);
    check_eq("bp_level", fifo_level, 4);
    check_eq("bp_valid", AXIM_axvalid, 1);
    check_eq("bp_addr_a", AXIM_axaddr, 64'h4000);
    step(); step(); step();
    check_eq("bp_addr_b", AXIM_axaddr, 64'h4000);
    check_eq("bp_id_b", AXIM_axid, 16);
    check_eq("bp_valid_b", AXIM_axvalid, 1);
    AXIM_axready = 1'b1;
    wait_ax("bp_drain", 4, 20);
    if (ax_addr.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        check_eq($sformatf("bp_order%0d", k), ax_addr[k], 64'h4000 + 64'(k * 16'h100));
        if (k > 0) check_eq($sformatf("bp_gap%0d", k), ax_cyc[k] - ax_cyc[k-1], 2);
      end
    end
    step(); step(); step();
    check_eq("bp_level_end", fifo_level, 0);

    // Paced replay: deltas 30 and 1; issue waits until elapsed reaches delta
    clear_logs();
    pace_en = 1'b1;
    send_rec(mk_rec(3'd0, 32'd1, 8'd0, 20'd100, 64'h100), 4, ok);
    send_rec(mk_rec(3'd0, 32'd2, 8'd0, 20'd130, 64'h200), 4, ok);
    send_rec(mk_rec(3'd0, 32'd3, 8'd0, 20'd131, 64'h300), 4, ok);
    wait_ax("pace_issue", 3, 200);
    if (ax_cyc.size() == 3 && st_cyc.size() == 3) begin
      check_eq("pace_first_unpaced", ax_cyc[0] - st_cyc[0], 2);
      // elapsed reads 0 the cycle after the handshake, so delta d gives issue d+2 later
      check_eq("pace_gap30", ax_cyc[1] - ax_cyc[0], 32);
      check_eq("pace_gap1", ax_cyc[2] - ax_cyc[1], 3);
      check_eq("pace_order", ax_addr[2], 64'h300);
    end

    // Timestamp wrap: 0xFFFF0 -> 0x00010 is a delta of 32
    step(); step(); step();
    clear_logs();
    send_rec(mk_rec(3'd0, 32'd7, 8'd0, 20'hFFFF0, 64'h500), 4, ok);
    send_rec(mk_rec(3'd0, 32'd8, 8'd0, 20'h00010, 64'h600), 4, ok);
    wait_ax("wrap_issue", 2, 200);
    if (ax_cyc.size() == 2 && st_cyc.size() == 2) begin
      check_eq("wrap_first_unpaced", ax_cyc[0] - st_cyc[0], 2);
      check_eq("wrap_gap32", ax_cyc[1] - ax_cyc[0], 34);
    end

    // Asynchronous reset in the middle of ISSUE
    step(); step(); step();
    pace_en = 1'b0;
    AXIM_axready = 1'b0;
    clear_logs();
    for (int k = 0; k < 3; k++)
      send_rec(mk_rec(3'd0, 32'(k), 8'd0, 20'(k), 64'h800 + 64'(k)), 4, ok);
    step();
    check_eq("arst_pre_valid", AXIM_axvalid, 1);
    check_eq("arst_pre_level", fifo_level, 3);
    #1 resetn = 1'b0;
    #1;
    check_eq("arst_valid", AXIM_axvalid, 0);
    check_eq("arst_level", fifo_level, 0);
    step(); step();
    resetn = 1'b1;
    AXIM_axready = 1'b1;
    step();
    check_eq("arst_ready", stream_ready, 1);
    clear_logs();
    send_rec(mk_rec(3'd0, 32'd42, 8'd2, 20'd77, 64'hABC0), 4, ok);
    wait_ax("arst_new_issue", 1, 10);
    if (ax_cyc.size() == 1 && st_cyc.size() == 1) begin
      check_eq("arst_new_addr", ax_addr[0], 64'hABC0);
      check_eq("arst_new_latency", ax_cyc[0] - st_cyc[0], 2);
    end
    step(); step();
    check_eq("arst_new_count", ax_addr.size(), 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
